// File: rtl/register_bank_wb_pkg.sv
// Shared widths and types for the write-back register bank and its
// per-register pending-write scoreboard.
package reg_bank_pkg;
  localparam int DATA_WIDTH     = 24;
  localparam int REG_COUNT      = 16;
  localparam int REG_ADDR_WIDTH = 4;
  localparam int MAX_INFLIGHT   = 3;

  typedef logic [1:0]                pend_cnt_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0]     reg_data_t;

  localparam pend_cnt_t CNT_MAX = pend_cnt_t'(MAX_INFLIGHT);
endpackage

// File: rtl/register_bank_wb_if.sv
// Decode/write-back side bundle for the register bank; the bank is the slave.
interface register_bank_wb_if;
  import reg_bank_pkg::*;

  reg_addr_t rd_addr_a_in;
  reg_addr_t rd_addr_b_in;
  reg_data_t rd_data_a_out;
  reg_data_t rd_data_b_out;
  logic      src_a_used_in;
  logic      src_b_used_in;
  logic      issue_valid_in;
  logic      issue_writes_in;
  reg_addr_t issue_dest_in;
  logic      wb_en_in;
  reg_addr_t wb_addr_in;
  reg_data_t wb_data_in;
  logic      flush_in;
  logic      stall_out;
  logic      err_out;

  modport master (
    output rd_addr_a_in, rd_addr_b_in, src_a_used_in, src_b_used_in,
           issue_valid_in, issue_writes_in, issue_dest_in,
           wb_en_in, wb_addr_in, wb_data_in, flush_in,
    input  rd_data_a_out, rd_data_b_out, stall_out, err_out
  );

  modport slave (
    input  rd_addr_a_in, rd_addr_b_in, src_a_used_in, src_b_used_in,
           issue_valid_in, issue_writes_in, issue_dest_in,
           wb_en_in, wb_addr_in, wb_data_in, flush_in,
    output rd_data_a_out, rd_data_b_out, stall_out, err_out
  );
endinterface

// File: rtl/register_bank_wb_pending_counter.sv
// Outstanding-write counter for one register: clear wins, inc+dec together hold,
// a decrement at zero is reported as underflow and leaves the count at zero.
module pending_counter
  import reg_bank_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      inc,
  input  logic      dec,
  input  logic      clr,
  output pend_cnt_t count,
  output logic      underflow
);
  pend_cnt_t r_count;
  pend_cnt_t w_count_next;

  always_comb begin
    w_count_next = r_count;
    if (clr)
      w_count_next = '0;
    else if (inc && dec)
      w_count_next = r_count;
    else if (inc)
      w_count_next = r_count + pend_cnt_t'(1);
    else if (dec && r_count != '0)
      w_count_next = r_count - pend_cnt_t'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= '0;
    else
      r_count <= w_count_next;
  end

  assign count     = r_count;
  assign underflow = dec && (r_count == '0);
endmodule

// File: rtl/register_bank_wb.sv
// 16 x 24-bit register bank with write-back bypass on both read ports and a
// pending-write scoreboard that produces the decode stall.
module register_bank_wb
  import reg_bank_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  register_bank_wb_if.slave  bus
);
  reg_data_t            r_mem [REG_COUNT];
  pend_cnt_t            w_cnt [REG_COUNT];
  pend_cnt_t            w_eff [REG_COUNT];
  logic [REG_COUNT-1:0] w_inc;
  logic [REG_COUNT-1:0] w_dec;
  logic [REG_COUNT-1:0] w_underflow;
  logic                 w_hazard;
  logic                 w_stall;
  logic                 w_accept;
  logic                 w_err_set;
  logic [1:0]           r_flush_shadow;
  logic                 r_err;

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_pend
      assign w_inc[gi] = w_accept && (bus.issue_dest_in == reg_addr_t'(gi));
      assign w_dec[gi] = bus.wb_en_in && (bus.wb_addr_in == reg_addr_t'(gi));
      // Count as decode sees it once this cycle's write-back retires.
      assign w_eff[gi] = w_cnt[gi] - pend_cnt_t'(w_dec[gi] && (w_cnt[gi] != '0));

      pending_counter u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (w_inc[gi]),
        .dec       (w_dec[gi]),
        .clr       (bus.flush_in),
        .count     (w_cnt[gi]),
        .underflow (w_underflow[gi])
      );
    end
  endgenerate

  assign w_hazard = (bus.src_a_used_in   && (w_eff[bus.rd_addr_a_in]  != '0))
                 || (bus.src_b_used_in   && (w_eff[bus.rd_addr_b_in]  != '0))
                 || (bus.issue_writes_in && (w_eff[bus.issue_dest_in] == CNT_MAX));
  assign w_stall  = bus.issue_valid_in && !bus.flush_in && w_hazard;
  assign w_accept = bus.issue_valid_in && bus.issue_writes_in && !w_stall && !bus.flush_in;

  // Write-backs still draining from before a flush hit zeroed counters legally.
  assign w_err_set = bus.wb_en_in && w_underflow[bus.wb_addr_in]
                  && !bus.flush_in && (r_flush_shadow == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_shadow <= 2'd0;
      r_err          <= 1'b0;
    end else begin
      if (bus.flush_in)
        r_flush_shadow <= 2'd2;
      else if (r_flush_shadow != 2'd0)
        r_flush_shadow <= r_flush_shadow - 2'd1;
      if (w_err_set)
        r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++)
        r_mem[i] <= '0;
    end else if (bus.wb_en_in) begin
      r_mem[bus.wb_addr_in] <= bus.wb_data_in;
    end
  end

  assign bus.rd_data_a_out = (bus.wb_en_in && bus.wb_addr_in == bus.rd_addr_a_in)
                           ? bus.wb_data_in : r_mem[bus.rd_addr_a_in];
  assign bus.rd_data_b_out = (bus.wb_en_in && bus.wb_addr_in == bus.rd_addr_b_in)
                           ? bus.wb_data_in : r_mem[bus.rd_addr_b_in];
  assign bus.stall_out     = w_stall;
  assign bus.err_out       = r_err;
endmodule

// File: tb/tb_register_bank_wb.sv
// Directed bench for register_bank_wb: bypass, scoreboard stall, saturation,
// flush shadow and sticky error, checked with immediate assertions.
module tb_register_bank_wb;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  register_bank_wb_if bus ();

  register_bank_wb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.rd_addr_a_in    = 4'd0;
    bus.rd_addr_b_in    = 4'd0;
    bus.src_a_used_in   = 1'b0;
    bus.src_b_used_in   = 1'b0;
    bus.issue_valid_in  = 1'b0;
    bus.issue_writes_in = 1'b0;
    bus.issue_dest_in   = 4'd0;
    bus.wb_en_in        = 1'b0;
    bus.wb_addr_in      = 4'd0;
    bus.wb_data_in      = 24'd0;
    bus.flush_in        = 1'b0;
  endtask

  task automatic issue(input logic [3:0] dest);
    idle();
    bus.issue_valid_in  = 1'b1;
    bus.issue_writes_in = 1'b1;
    bus.issue_dest_in   = dest;
  endtask

  task automatic wb(input logic [3:0] addr, input logic [23:0] data);
    bus.wb_en_in   = 1'b1;
    bus.wb_addr_in = addr;
    bus.wb_data_in = data;
  endtask

  task automatic use_a(input logic [3:0] addr);
    bus.issue_valid_in = 1'b1;
    bus.src_a_used_in  = 1'b1;
    bus.rd_addr_a_in   = addr;
  endtask

  // Apply the current inputs at the next rising edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst_n = 1'b0;

    // Reset state
    bus.rd_addr_a_in = 4'd3;
    bus.rd_addr_b_in = 4'd7;
    #12;
    check("reset_rd_a", 32'(bus.rd_data_a_out), 32'h0);
    check("reset_rd_b", 32'(bus.rd_data_b_out), 32'h0);
    check("reset_stall", 32'(bus.stall_out), 32'h0);
    check("reset_err", 32'(bus.err_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Issue r5, write back three cycles later, read through bypass
    issue(4'd5);
    #1 check("issue_r5_stall", 32'(bus.stall_out), 32'h0);
    tick();
    idle(); tick(); tick();
    idle(); use_a(4'd5); bus.rd_addr_b_in = 4'd5; bus.src_b_used_in = 1'b1;
    wb(4'd5, 24'h00ABCD);
    #1;
    check("wb_r5_stall", 32'(bus.stall_out), 32'h0);
    check("wb_r5_bypass_a", 32'(bus.rd_data_a_out), 32'h00ABCD);
    check("wb_r5_bypass_b", 32'(bus.rd_data_b_out), 32'h00ABCD);
    tick();
    idle(); use_a(4'd5);
    #1;
    check("r5_array_read", 32'(bus.rd_data_a_out), 32'h00ABCD);
    check("r5_cnt_zero_nostall", 32'(bus.stall_out), 32'h0);
    check("r5_no_err", 32'(bus.err_out), 32'h0);
    tick();

    // Saturate r2 at three outstanding writes
    for (int i = 0; i < 3; i++) begin
      issue(4'd2);
      #1 check($sformatf("r2_issue%0d_stall", i), 32'(bus.stall_out), 32'h0);
      tick();
    end
    issue(4'd2);
    #1 check("r2_issue4_stall", 32'(bus.stall_out), 32'h1);
    tick();
    idle(); use_a(4'd2); wb(4'd2, 24'h000111);
    #1 check("r2_src_eff2_stall", 32'(bus.stall_out), 32'h1);
    tick();
    // One write-back just retired: count is 2, so issue a third again
    issue(4'd2);
    #1 check("r2_refill_stall", 32'(bus.stall_out), 32'h0);
    tick();
    issue(4'd2); wb(4'd2, 24'h000222);
    #1 check("r2_issue_with_wb_stall", 32'(bus.stall_out), 32'h0);
    tick();
    issue(4'd2);
    #1 check("r2_still_full_stall", 32'(bus.stall_out), 32'h1);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(); wb(4'd2, 24'h000300 + 24'(i));
      tick();
    end
    idle(); use_a(4'd2);
    #1;
    check("r2_drained_stall", 32'(bus.stall_out), 32'h0);
    check("r2_last_value", 32'(bus.rd_data_a_out), 32'h000302);
    check("r2_drained_err", 32'(bus.err_out), 32'h0);
    tick();

    // Source dependency resolved in the final write-back cycle
    issue(4'd4);
    tick();
    idle(); use_a(4'd4);
    #1 check("r4_src_stall", 32'(bus.stall_out), 32'h1);
    tick();
    idle(); use_a(4'd4); wb(4'd4, 24'h123456);
    #1;
    check("r4_wb_stall", 32'(bus.stall_out), 32'h0);
    check("r4_wb_bypass", 32'(bus.rd_data_a_out), 32'h123456);
    tick();

    // Flush with two writes pending on r1, then two late write-backs
    issue(4'd1); tick();
    issue(4'd1); tick();
    idle(); use_a(4'd1); bus.flush_in = 1'b1;
    #1 check("flush_stall", 32'(bus.stall_out), 32'h0);
    tick();
    idle(); wb(4'd1, 24'h111111); tick();
    idle(); wb(4'd1, 24'h222222); tick();
    idle(); use_a(4'd1);
    #1;
    check("post_flush_err", 32'(bus.err_out), 32'h0);
    check("post_flush_r1", 32'(bus.rd_data_a_out), 32'h222222);
    check("post_flush_nostall", 32'(bus.stall_out), 32'h0);
    tick();

    // Stray write-back to r9 sets the sticky error
    idle(); wb(4'd9, 24'h000999);
    #1 check("r9_err_before_edge", 32'(bus.err_out), 32'h0);
    tick();
    check("r9_err_set", 32'(bus.err_out), 32'h1);
    idle(); tick(); tick();
    bus.rd_addr_b_in = 4'd9;
    #1;
    check("r9_err_sticky", 32'(bus.err_out), 32'h1);
    check("r9_array_written", 32'(bus.rd_data_b_out), 32'h000999);

    // Asynchronous reset mid-operation clears everything at once
    #2 rst_n = 1'b0;
    bus.rd_addr_a_in = 4'd4;
    #1;
    check("async_rst_err", 32'(bus.err_out), 32'h0);
    check("async_rst_r9", 32'(bus.rd_data_b_out), 32'h0);
    check("async_rst_r4", 32'(bus.rd_data_a_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
